// File: rtl/bist_serdes_pkg.sv
// Shared types and constants for the bist_serdes serial shifter.
package bist_serdes_pkg;

    localparam int CLKDIV_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/bist_stb_gen.sv
// Shift-rate strobe generator: pulses stb once every load_val+1 enabled cycles.
// The divide value is captured on clr so it stays stable for a whole transfer.
module bist_stb_gen
    import bist_serdes_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                en,
    input  logic [CLKDIV_W-1:0] load_val,
    output logic                stb
);

    logic [CLKDIV_W-1:0] cnt_q, cnt_d;
    logic [CLKDIV_W-1:0] div_q, div_d;

    always_comb begin
        cnt_d = cnt_q;
        div_d = div_q;
        stb   = en && (cnt_q == div_q);
        if (clr) begin
            cnt_d = '0;
            div_d = load_val;
        end else if (en) begin
            cnt_d = stb ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            div_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/bist_serdes.sv
// Bidirectional-order serializer/deserializer with length control and abort.
// Optional shift-rate divider enabled by defining BIST_SERDES_CLKDIV_EN.
module bist_serdes
    import bist_serdes_pkg::*;
#(
    parameter int WD = 32,
    parameter int CW = $clog2(WD + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef BIST_SERDES_CLKDIV_EN
    input  logic [CLKDIV_W-1:0] clk_div,
`endif
    input  logic                start,
    input  logic                abort,
    input  logic [CW-1:0]       len,
    input  logic                msb_first,
    input  logic [WD-1:0]       load_data,
    input  logic                sdi,
    output logic                sdo,
    output logic                shift_stb,
    output logic                busy,
    output logic                done,
    output logic [WD-1:0]       rx_data
);

    state_e        state_q, state_d;
    logic [WD-1:0] shift_q, shift_d;
    logic [WD-1:0] rx_q, rx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] len_q, len_d;
    logic          msb_q, msb_d;

    logic [CW-1:0] eff_len;
    logic [WD-1:0] shifted;
    logic [WD-1:0] rx_mask;
    logic          in_shift;
    logic          start_ok;
    logic          stb_raw;
    logic          stb;

    assign in_shift = (state_q == SHIFT);
    assign start_ok = (state_q == IDLE) && start;

`ifdef BIST_SERDES_CLKDIV_EN
    bist_stb_gen u_stb_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (start_ok),
        .en       (in_shift),
        .load_val (clk_div),
        .stb      (stb_raw)
    );
`else
    assign stb_raw = 1'b1;
`endif

    // Abort wins over a pending strobe, so no bit moves in the abort cycle.
    assign stb = in_shift && stb_raw && !abort;

    always_comb begin
        eff_len = len;
        if ((len == '0) || (len > CW'(WD)))
            eff_len = CW'(WD);
    end

    assign shifted = msb_q ? {shift_q[WD-2:0], sdi} : {sdi, shift_q[WD-1:1]};
    assign rx_mask = (len_q >= CW'(WD)) ? '1 : ((WD'(1) << len_q) - WD'(1));

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        rx_d    = rx_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        msb_d   = msb_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = load_data;
                    cnt_d   = eff_len;
                    len_d   = eff_len;
                    msb_d   = msb_first;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (stb) begin
                    shift_d = shifted;
                    cnt_d   = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_d = DONE;
                        // LSB-first data lands at the top of the register; right-justify it.
                        rx_d = msb_q ? (shifted & rx_mask)
                                     : (shifted >> (WD - int'(len_q)));
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            rx_q    <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            msb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            msb_q   <= msb_d;
        end
    end

    assign sdo       = msb_q ? shift_q[WD-1] : shift_q[0];
    assign shift_stb = stb;
    assign busy      = in_shift;
    assign done      = (state_q == DONE);
    assign rx_data   = rx_q;

endmodule

// File: tb/tb_bist_serdes.sv
// Directed self-checking bench for bist_serdes; divider case runs when
// BIST_SERDES_CLKDIV_EN is defined.
module tb_bist_serdes;

    localparam int WD = 32;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] len = '0;
    logic          msb_first = 1'b0;
    logic [WD-1:0] load_data = '0;
    logic          sdi = 1'b0;
    logic [7:0]    clk_div = '0;
    logic          sdo;
    logic          shift_stb;
    logic          busy;
    logic          done;
    logic [WD-1:0] rx_data;

    int total = 0;
    int bad = 0;

    bist_serdes #(.WD(WD), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef BIST_SERDES_CLKDIV_EN
        .clk_div   (clk_div),
`endif
        .start     (start),
        .abort     (abort),
        .len       (len),
        .msb_first (msb_first),
        .load_data (load_data),
        .sdi       (sdi),
        .sdo       (sdo),
        .shift_stb (shift_stb),
        .busy      (busy),
        .done      (done),
        .rx_data   (rx_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One transfer; sdi either loops sdo back or follows sdi_pat bit i on strobe i.
    task automatic do_xfer(input string nm, input logic [CW-1:0] ln, input logic m,
                           input logic [31:0] d, input logic [31:0] sdi_pat, input logic loopb,
                           input int n, input int dv, input logic [31:0] exp_sdo,
                           input logic [31:0] exp_rx);
        int i = 0;
        int done_k = 0;
        @(negedge clk);
        len = ln; msb_first = m; load_data = d; clk_div = dv[7:0]; sdi = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; load_data = '0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (shift_stb) begin
                chk({nm, "_stbpos"}, 64'(k), 64'((i + 1) * (dv + 1)));
                if (i < 32) chk({nm, "_sdo"}, {63'd0, sdo}, {63'd0, exp_sdo[i]});
                sdi = loopb ? sdo : ((i < 32) ? sdi_pat[i] : 1'b0);
                i++;
            end
            if (done) begin
                done_k = k;
                break;
            end
        end
        chk({nm, "_nstb"}, 64'(i), 64'(n));
        chk({nm, "_donecyc"}, 64'(done_k), 64'(n * (dv + 1) + 1));
        chk({nm, "_rx"}, {32'd0, rx_data}, {32'd0, exp_rx});
        @(negedge clk);
        chk({nm, "_done1"}, {63'd0, done}, 64'd0);
        chk({nm, "_idle"}, {63'd0, busy}, 64'd0);
        $display("xfer %s: len=%0d strobes=%0d done_at=%0d rx=%08h", nm, ln, i, done_k, rx_data);
    endtask

    initial begin
        int i;
        int seen;
        int kk;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_sdo", {63'd0, sdo}, 64'd0);
        chk("rst_stb", {63'd0, shift_stb}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_rx", {32'd0, rx_data}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", {63'd0, busy}, 64'd0);
        $display("xfer reset: outputs idle");

        do_xfer("lsb_full", 6'd0, 1'b0, 32'hA5A5_0F0F, 32'h0, 1'b1, 32, 0,
                32'hA5A5_0F0F, 32'hA5A5_0F0F);
        do_xfer("msb8", 6'd8, 1'b1, 32'h0000_00C3, 32'h0000_004D, 1'b0, 8, 0,
                32'h0, 32'h0000_00B2);
        do_xfer("lsb4", 6'd4, 1'b0, 32'h0000_0005, 32'hFFFF_FFFF, 1'b0, 4, 0,
                32'h0000_0005, 32'h0000_000F);
        do_xfer("msb_ovr", 6'd40, 1'b1, 32'h1234_5678, 32'h0, 1'b1, 32, 0,
                32'h1E6A_2C48, 32'h1234_5678);

        // Abort at the 5th strobe of a 16-bit LSB-first transfer
        @(negedge clk);
        len = 6'd16; msb_first = 1'b0; load_data = 32'h0000_1234; clk_div = '0; sdi = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        i = 0; kk = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (shift_stb) i++;
            if (i == 5) begin
                kk = k;
                break;
            end
        end
        chk("abort_stb5_pos", 64'(kk), 64'd5);
        abort = 1'b1;
        #1 chk("abort_gates_stb", {63'd0, shift_stb}, 64'd0);
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_rx", {32'd0, rx_data}, {32'd0, 32'h1234_5678});
        chk("abort_reg_kept", {63'd0, sdo}, 64'd1);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        chk("abort_no_done", 64'(seen), 64'd0);
        $display("xfer abort: strobes=%0d busy=%0b rx=%08h", i, busy, rx_data);

        do_xfer("post_abort", 6'd1, 1'b0, 32'h0000_0001, 32'h0000_0001, 1'b0, 1, 0,
                32'h0000_0001, 32'h0000_0001);

        // Start while busy is ignored, then reset mid-transfer
        @(negedge clk);
        len = 6'd8; msb_first = 1'b0; load_data = 32'h0000_00FF; sdi = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        i = 0; kk = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (shift_stb) begin
                i++;
                if (i >= 4) chk("busy_start_sdo", {63'd0, sdo}, 64'd1);
                if (i == 3) begin
                    start = 1'b1; load_data = '0; len = 6'd2;
                end
            end
            if (i == 6) begin
                kk = k;
                break;
            end
        end
        chk("busy_start_pos6", 64'(kk), 64'd6);
        rst_n = 1'b0;
        #1;
        chk("midrst_sdo", {63'd0, sdo}, 64'd0);
        chk("midrst_stb", {63'd0, shift_stb}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_rx", {32'd0, rx_data}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy || shift_stb || sdo) seen = 1;
        end
        chk("midrst_quiet", 64'(seen), 64'd0);
        $display("xfer midreset: strobes_before_reset=%0d quiet=%0d", i, seen == 0);

`ifdef BIST_SERDES_CLKDIV_EN
        do_xfer("div3", 6'd2, 1'b0, 32'h0000_0003, 32'h0000_0001, 1'b0, 2, 3,
                32'h0000_0003, 32'h0000_0001);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
